// File: rtl/mand_dispatcher_if.sv
// mand_dispatcher_if: frame request, solver slot and result signals of the Mandelbrot dispatcher.
interface mand_dispatcher_if #(
   parameter int N_SOLVERS = 4,
   parameter int XW = 10,
   parameter int YW = 10
);
   logic start;
   logic signed [26:0] re0, im0, step_re, step_im;
   logic [XW-1:0] width;
   logic [YW-1:0] height;
   logic [N_SOLVERS-1:0] solver_reset, solver_ready;
   logic [27*N_SOLVERS-1:0] solver_c_re, solver_c_im;
   logic [32*N_SOLVERS-1:0] solver_out;
   logic res_valid, res_ready;
   logic [XW-1:0] res_x;
   logic [YW-1:0] res_y;
   logic [31:0] res_iter;
   logic busy, frame_done;
   modport master (
      output start, re0, im0, step_re, step_im, width, height, solver_ready, solver_out, res_ready,
      input solver_reset, solver_c_re, solver_c_im, res_valid, res_x, res_y, res_iter, busy, frame_done
   );
   modport slave (
      input start, re0, im0, step_re, step_im, width, height, solver_ready, solver_out, res_ready,
      output solver_reset, solver_c_re, solver_c_im, res_valid, res_x, res_y, res_iter, busy, frame_done
   );
endinterface

// File: rtl/mand_dispatcher.sv
// mand_dispatcher: scans a frame in raster order, hands pixels to free solver slots and
// funnels finished iteration counts through a single valid/ready result register.
module mand_dispatcher #(
   parameter int N_SOLVERS = 4,
   parameter int XW = 10,
   parameter int YW = 10
) (
   input logic clk,
   input logic rst,
   mand_dispatcher_if.slave bus
);
   localparam int IW = N_SOLVERS > 1 ? $clog2(N_SOLVERS) : 1;
   localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2;
   localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3;
   localparam logic [XW-1:0] X1 = 1;
   localparam logic [YW-1:0] Y1 = 1;

   logic [1:0] state;
   logic [1:0] slot [N_SOLVERS];
   logic [XW-1:0] tag_x [N_SOLVERS];
   logic [YW-1:0] tag_y [N_SOLVERS];
   logic [27*N_SOLVERS-1:0] c_re, c_im;
   logic [N_SOLVERS-1:0] sreset;
   logic signed [26:0] re0_q, step_re_q, step_im_q, cur_re, cur_im;
   logic [XW-1:0] width_q, cur_x, res_x;
   logic [YW-1:0] height_q, cur_y, res_y;
   logic [31:0] res_iter;
   logic res_valid, frame_done;
   logic free_any, done_any, all_idle, empty, dispatch, take, row_end, last;
   logic [IW-1:0] free_idx, done_idx;

   // Descending scan so the lowest-index candidate wins.
   always_comb begin
      free_any = 1'b0;
      done_any = 1'b0;
      all_idle = 1'b1;
      free_idx = '0;
      done_idx = '0;
      sreset = '0;
      for (int i = N_SOLVERS - 1; i >= 0; i--) begin
         sreset[i] = !slot[i][1];
         if (slot[i] != S_IDLE) all_idle = 1'b0;
         if (slot[i] == S_IDLE) begin
            free_any = 1'b1;
            free_idx = IW'(i);
         end
         if (slot[i] == S_DONE) begin
            done_any = 1'b1;
            done_idx = IW'(i);
         end
      end
   end

   assign empty = width_q == '0 || height_q == '0;
   assign dispatch = state == SCAN && !empty && free_any;
   assign take = done_any && (!res_valid || bus.res_ready);
   assign row_end = cur_x + X1 == width_q;
   assign last = row_end && cur_y + Y1 == height_q;

   assign bus.solver_reset = sreset;
   assign bus.solver_c_re = c_re;
   assign bus.solver_c_im = c_im;
   assign bus.res_valid = res_valid;
   assign bus.res_x = res_x;
   assign bus.res_y = res_y;
   assign bus.res_iter = res_iter;
   assign bus.busy = state != IDLE;
   assign bus.frame_done = frame_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         for (int i = 0; i < N_SOLVERS; i++) begin
            slot[i] <= S_IDLE;
            tag_x[i] <= '0;
            tag_y[i] <= '0;
         end
         c_re <= '0;
         c_im <= '0;
         re0_q <= '0;
         step_re_q <= '0;
         step_im_q <= '0;
         width_q <= '0;
         height_q <= '0;
         cur_re <= '0;
         cur_im <= '0;
         cur_x <= '0;
         cur_y <= '0;
         res_valid <= 1'b0;
         res_x <= '0;
         res_y <= '0;
         res_iter <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (state == IDLE && bus.start) begin
            state <= SCAN;
            re0_q <= bus.re0;
            step_re_q <= bus.step_re;
            step_im_q <= bus.step_im;
            width_q <= bus.width;
            height_q <= bus.height;
            cur_re <= bus.re0;
            cur_im <= bus.im0;
            cur_x <= '0;
            cur_y <= '0;
         end else if (state == SCAN && empty) begin
            state <= IDLE;
            frame_done <= 1'b1;
         end else if (dispatch) begin
            state <= last ? DRAIN : SCAN;
            cur_x <= row_end ? '0 : cur_x + X1;
            cur_y <= row_end ? cur_y + Y1 : cur_y;
            cur_re <= row_end ? re0_q : cur_re + step_re_q;
            cur_im <= row_end ? cur_im + step_im_q : cur_im;
         end else if (state == DRAIN && all_idle && (!res_valid || bus.res_ready)) begin
            state <= IDLE;
            frame_done <= 1'b1;
         end
         for (int i = 0; i < N_SOLVERS; i++) begin
            if (slot[i] == S_IDLE && dispatch && free_idx == IW'(i)) begin
               slot[i] <= S_LOAD;
               c_re[27*i +: 27] <= cur_re;
               c_im[27*i +: 27] <= cur_im;
               tag_x[i] <= cur_x;
               tag_y[i] <= cur_y;
            end else if (slot[i] == S_LOAD) begin
               slot[i] <= S_RUN;
            end else if (slot[i] == S_RUN && bus.solver_ready[i]) begin
               slot[i] <= S_DONE;
            end else if (slot[i] == S_DONE && take && done_idx == IW'(i)) begin
               slot[i] <= S_IDLE;
            end
         end
         if (take) begin
            res_valid <= 1'b1;
            res_x <= tag_x[done_idx];
            res_y <= tag_y[done_idx];
            res_iter <= bus.solver_out[32*done_idx +: 32];
         end else if (bus.res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mand_dispatcher.sv
// tb_mand_dispatcher: behavioural solvers plus a raster-order pixel model check the dispatcher.
module tb_mand_dispatcher;
   localparam int N = 4, XW = 10, YW = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mand_dispatcher_if #(.N_SOLVERS(N), .XW(XW), .YW(YW)) bus ();
   mand_dispatcher #(.N_SOLVERS(N), .XW(XW), .YW(YW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {int x; int y; int it;} res_t;

   int errors = 0, checks = 0, cyc = 0;
   res_t results[$];
   logic signed [26:0] disp_re[$], disp_im[$];
   int fd_cnt, fd_cyc, busy_cnt, rel_cnt, stall_bad, load_cyc, first_valid_cyc, start_cyc;
   int max_delay = 3, ready_mode = 0;
   int cnt[N], iters[N];
   bit run[N];
   bit stalled_prev = 1'b0;
   int px, py, pit;
   logic signed [26:0] f_re0, f_im0, f_sre, f_sim;
   int f_w, f_h;

   always @(posedge clk) cyc <= cyc + 1;

   // Escape-time count with limit 100; -1 when the orbit never leaves |z|<=2.
   function automatic int mand(logic signed [26:0] cr, logic signed [26:0] ci);
      int ir, ii;
      real a, b, x, y, t;
      ir = cr;
      ii = ci;
      a = ir / 1048576.0;
      b = ii / 1048576.0;
      x = 0.0;
      y = 0.0;
      for (int n = 0; n < 100; n++) begin
         t = x * x - y * y + a;
         y = 2.0 * x * y + b;
         x = t;
         if (x * x + y * y > 4.0) return n;
      end
      return -1;
   endfunction

   function automatic logic signed [26:0] exp_re(int x);
      return f_re0 + f_sre * 27'(x);
   endfunction

   function automatic logic signed [26:0] exp_im(int y);
      return f_im0 + f_sim * 27'(y);
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (bus.solver_reset[i]) begin
            run[i] = 1'b0;
            bus.solver_ready[i] = 1'b0;
         end else begin
            if (!run[i]) begin
               run[i] = 1'b1;
               rel_cnt++;
               disp_re.push_back(bus.solver_c_re[27*i +: 27]);
               disp_im.push_back(bus.solver_c_im[27*i +: 27]);
               load_cyc = cyc - 1;
               iters[i] = mand(bus.solver_c_re[27*i +: 27], bus.solver_c_im[27*i +: 27]);
               cnt[i] = $urandom_range(0, max_delay);
            end
            if (cnt[i] == 0) begin
               bus.solver_ready[i] = 1'b1;
               bus.solver_out[32*i +: 32] = iters[i];
            end else begin
               cnt[i]--;
            end
         end
      end
      if (bus.busy) busy_cnt++;
      if (bus.frame_done) begin
         fd_cnt++;
         fd_cyc = cyc;
      end
      if (stalled_prev && (!bus.res_valid || int'(bus.res_x) != px || int'(bus.res_y) != py || int'(bus.res_iter) != pit))
         stall_bad++;
      bus.res_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      if (bus.res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.res_valid && bus.res_ready) results.push_back('{int'(bus.res_x), int'(bus.res_y), int'(bus.res_iter)});
      stalled_prev = bus.res_valid && !bus.res_ready;
      px = int'(bus.res_x);
      py = int'(bus.res_y);
      pit = int'(bus.res_iter);
   end

   task automatic clear_model();
      results.delete();
      disp_re.delete();
      disp_im.delete();
      fd_cnt = 0;
      busy_cnt = 0;
      rel_cnt = 0;
      stall_bad = 0;
      first_valid_cyc = -1;
   endtask

   task automatic set_frame(logic signed [26:0] r0, logic signed [26:0] i0, logic signed [26:0] sr, logic signed [26:0] si, int w, int h);
      f_re0 = r0;
      f_im0 = i0;
      f_sre = sr;
      f_sim = si;
      f_w = w;
      f_h = h;
   endtask

   task automatic do_start();
      @(negedge clk);
      bus.re0 = f_re0;
      bus.im0 = f_im0;
      bus.step_re = f_sre;
      bus.step_im = f_sim;
      bus.width = XW'(f_w);
      bus.height = YW'(f_h);
      bus.start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_frame(string name, int budget);
      int n = 0;
      while (fd_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (fd_cnt == 0) begin
         errors++;
         $display("FAIL %s timeout: frame_done not seen after %0d cycles, required within %0d", name, n, budget);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_frame(string name);
      int seen[16][16];
      int e;
      foreach (seen[a, b]) seen[a][b] = 0;
      checks++;
      if (results.size() != f_w * f_h) begin
         errors++;
         $display("FAIL %s count: got %0d results, required %0d", name, results.size(), f_w * f_h);
      end
      foreach (results[k]) begin
         checks++;
         if (results[k].x < 0 || results[k].x >= f_w || results[k].y < 0 || results[k].y >= f_h ||
             seen[results[k].y][results[k].x] != 0) begin
            errors++;
            $display("FAIL %s pixel: got (%0d,%0d) out of range or duplicate", name, results[k].x, results[k].y);
            continue;
         end
         seen[results[k].y][results[k].x] = 1;
         e = mand(exp_re(results[k].x), exp_im(results[k].y));
         checks++;
         if (results[k].it !== e) begin
            errors++;
            $display("FAIL %s iter (%0d,%0d): got %0d, required %0d", name, results[k].x, results[k].y, results[k].it, e);
         end
      end
      checks++;
      if (disp_re.size() != f_w * f_h) begin
         errors++;
         $display("FAIL %s dispatches: got %0d, required %0d", name, disp_re.size(), f_w * f_h);
      end
      foreach (disp_re[k]) begin
         checks++;
         if (disp_re[k] !== exp_re(k % f_w) || disp_im[k] !== exp_im(k / f_w)) begin
            errors++;
            $display("FAIL %s c[%0d]: got %h/%h, required %h/%h", name, k, disp_re[k], disp_im[k], exp_re(k % f_w), exp_im(k / f_w));
         end
      end
      checks++;
      if (fd_cnt != 1) begin
         errors++;
         $display("FAIL %s frame_done pulses: got %0d, required 1", name, fd_cnt);
      end
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL %s stall stability: got %0d changes while stalled, required 0", name, stall_bad);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.solver_reset !== 4'hF) begin
         errors++;
         $display("FAIL reset ctrl: got busy=%b valid=%b done=%b sreset=%b, required 0 0 0 1111", bus.busy, bus.res_valid, bus.frame_done, bus.solver_reset);
      end
      checks++;
      if (bus.solver_c_re !== '0 || bus.solver_c_im !== '0 || bus.res_x !== '0 || bus.res_y !== '0 || bus.res_iter !== '0) begin
         errors++;
         $display("FAIL reset data: got c_re=%h c_im=%h x=%0d y=%0d iter=%h, required all zero", bus.solver_c_re, bus.solver_c_im, bus.res_x, bus.res_y, bus.res_iter);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_converged();
      clear_model();
      ready_mode = 0;
      max_delay = 3;
      set_frame(0, 0, 27'sd1048576, 27'sd1048576, 1, 1);
      do_start();
      wait_frame("converged", 200);
      check_frame("converged");
      checks++;
      if (results.size() != 1 || results[0].x != 0 || results[0].y != 0 || results[0].it != 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL converged result: got %0d results, first iter %h, required one (0,0) ffffffff", results.size(), results.size() > 0 ? results[0].it : 0);
      end
   endtask

   task automatic test_escape();
      clear_model();
      max_delay = 2;
      set_frame(27'sd3 <<< 20, 0, 0, 0, 1, 1);
      do_start();
      wait_frame("escape", 200);
      check_frame("escape");
      checks++;
      if (results.size() != 1 || results[0].it != 0) begin
         errors++;
         $display("FAIL escape iter: got %0d results, first iter %0d, required one with 0", results.size(), results.size() > 0 ? results[0].it : -2);
      end
      checks++;
      if (first_valid_cyc - load_cyc > 5 || first_valid_cyc - load_cyc < 3) begin
         errors++;
         $display("FAIL escape latency: got %0d cycles from LOAD, required 3..5", first_valid_cyc - load_cyc);
      end
   endtask

   task automatic test_frame();
      clear_model();
      ready_mode = 0;
      max_delay = 6;
      set_frame(-(27'sd2 <<< 20) + 27'($urandom_range(0, 1 << 16)), -(27'sd1 <<< 20),
                27'sd629146 + 27'($urandom_range(0, 4096)), 27'sd734003, 4, 3);
      do_start();
      repeat (3) @(negedge clk);
      bus.re0 = 27'sd3 <<< 20;
      bus.width = 1;
      bus.height = 1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_frame("frame", 500);
      check_frame("frame");
   endtask

   task automatic test_backpressure();
      clear_model();
      ready_mode = 1;
      max_delay = 10;
      do_start();
      repeat (8) @(negedge clk);
      ready_mode = 2;
      repeat (50) @(negedge clk);
      ready_mode = 1;
      wait_frame("backpressure", 1000);
      ready_mode = 0;
      repeat (2) @(negedge clk);
      check_frame("backpressure");
   endtask

   task automatic test_zero();
      for (int k = 0; k < 2; k++) begin
         clear_model();
         set_frame(27'sd1 <<< 20, 0, 27'sd1 <<< 18, 27'sd1 <<< 18, k == 0 ? 0 : 5, k == 0 ? 3 : 0);
         do_start();
         wait_frame("zero", 20);
         checks++;
         if (fd_cyc - start_cyc != 2 || busy_cnt != 1 || fd_cnt != 1) begin
            errors++;
            $display("FAIL zero%0d timing: got done at +%0d busy %0d pulses %0d, required +2 1 1", k, fd_cyc - start_cyc, busy_cnt, fd_cnt);
         end
         checks++;
         if (rel_cnt != 0 || results.size() != 0) begin
            errors++;
            $display("FAIL zero%0d activity: got %0d solver releases %0d results, required 0 0", k, rel_cnt, results.size());
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_model();
      ready_mode = 0;
      max_delay = 20;
      set_frame(-(27'sd1 <<< 20), 27'sd1 <<< 18, 27'sd1 <<< 18, 27'sd1 <<< 17, 4, 3);
      do_start();
      repeat (6) @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.solver_reset !== 4'hF || bus.res_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid state: got busy=%b sreset=%b valid=%b, required 0 1111 0", bus.busy, bus.solver_reset, bus.res_valid);
      end
      clear_model();
      repeat (30) @(negedge clk);
      checks++;
      if (fd_cnt != 0 || results.size() != 0) begin
         errors++;
         $display("FAIL reset_mid abort: got %0d pulses %0d results, required 0 0", fd_cnt, results.size());
      end
      max_delay = 5;
      set_frame(-(27'sd1 <<< 19), 27'sd1 <<< 19, 27'sd1 <<< 19, -(27'sd1 <<< 18), 2, 2);
      do_start();
      wait_frame("reset_mid", 300);
      check_frame("reset_mid");
   endtask

   initial begin
      bus.start = 1'b0;
      bus.re0 = '0;
      bus.im0 = '0;
      bus.step_re = '0;
      bus.step_im = '0;
      bus.width = '0;
      bus.height = '0;
      clear_model();
      test_reset();
      test_converged();
      test_escape();
      test_frame();
      test_backpressure();
      test_zero();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
